timer_multi: RTL
================

Name: timer_multi

Overview:
- Memory-mapped machine timer with its own 64-bit free-running mtime counter, a programmable prescaler, and CHANNELS independent 64-bit compare channels.
- Each channel drives a registered interrupt line.
- Sits on the CPU data bus as a peripheral. mtime_out also feeds the core's time CSR.
- Reading MTIMEL snapshots the upper half, so 64-bit reads are tear-free.

Parameters:
- CHANNELS, 2, number of compare channels/irq lines; legal range 1..8.
- PRESCALE_WIDTH, 16, width of the prescale divisor and prescale counter; legal range 1..32.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- address_in  in  32  byte address; only [6:2] decoded, block select done externally.
- sel_in  in  1  peripheral selected this cycle.
- read_in  in  1  read strobe, qualified by sel_in.
- read_value_out  out  32  combinational read data.
- write_mask_in  in  4  byte-lane write enables; all zero means no write.
- write_value_in  in  32  write data.
- irq_out  out  CHANNELS  per-channel timer interrupt, registered.
- mtime_out  out  64  current mtime value.

Behaviour:
- Word map, indexed by address_in[6:2]:
  - 0 MTIMEL
  - 1 MTIMEH
  - 2 CTRL: bit0 EN; bits[8+CHANNELS-1:8] IE[i]; other bits read 0
  - 3 PRESCALE: [PRESCALE_WIDTH-1:0] div
  - 4+2i CMPL_i
  - 5+2i CMPH_i, for i < CHANNELS
  - Any other index is unmapped: reads 0, writes ignored.
- Reset values (async, on reset_n low):
  - mtime = 0, presc_cnt = 0, EN = 0, IE = 0, div = 0, shadow_hi = 0.
  - All CMP registers = 64'hFFFF_FFFF_FFFF_FFFF.
  - irq_out = 0.
- Reads:
  - read_value_out is combinational and equals 0 whenever sel_in is low.
  - When sel_in is high it returns the decoded register, independent of read_in.
  - MTIMEH read returns shadow_hi, not the live mtime[63:32].
- Snapshot: on a posedge with sel_in & read_in at index 0, shadow_hi <= mtime[63:32], where mtime is the value returned by that same read.
- Writes:
  - A write occurs on posedge when sel_in is high; each byte lane updates independently per write_mask_in.
  - Writes to CMP, CTRL and PRESCALE take effect the next cycle.
  - Any write to PRESCALE also clears presc_cnt to 0.
- Prescaler and tick:
  - EN=0: presc_cnt held at 0, mtime frozen.
  - EN=1: if presc_cnt == div, then tick (mtime <= mtime+1) and presc_cnt <= 0; otherwise presc_cnt++.
  - div=0 gives a tick every cycle; div=N gives one tick per N+1 cycles.
- mtime arithmetic:
  - Unsigned 64-bit, wraps from all-ones to 0 with no flag.
  - A bus write to MTIMEL or MTIMEH in a tick cycle wins: the written bytes take write data, unwritten bytes keep their pre-cycle value, and the increment for that cycle is dropped.
  - The prescaler still advances in that cycle.
- Interrupts:
  - irq_out[i] <= IE[i] & (mtime >= CMP_i), an unsigned 64-bit compare using the current-cycle registered values.
  - Latency is one cycle after mtime or CMP reaches the asserting condition.
  - The line is level-type: it stays high until software raises CMP_i above mtime, clears IE[i], or mtime wraps below CMP_i.
- Simultaneous events:
  - A write to CMP_i in the same cycle mtime crosses it: the compare uses pre-write values that cycle and new values the next.
- mtime_out is the registered mtime. It does not reflect same-cycle writes until the next cycle.

Test Plan:
- Reset, then read all mapped words -> MTIME=0, CTRL=0, PRESCALE=0, every CMP word=32'hFFFFFFFF, irq_out=0; index 20 reads 0.
- Write PRESCALE=3, CTRL=1, wait 40 cycles -> mtime_out=10; EN=0 then freezes mtime_out at its current value.
- Write MTIMEL=FFFF_FFFE, MTIMEH=0, div=0, EN=1. Read MTIMEL, wait 5 cycles, read MTIMEH -> MTIMEH returns 0, the snapshot from the MTIMEL read, while the live mtime[63:32] is 1.
- Channel 1: CMP=0x100, IE[1]=1, mtime counting from 0xF0 at div=0 -> irq_out[1] rises exactly one cycle after mtime_out==0x100; irq_out[0] stays 0.
- With irq_out[1] high, write CMPL_1=0x200 -> irq_out[1] drops the cycle after the write. Write mask 4'b0001 with value 0xAB to CMPH_0 -> only CMP_0[39:32] changes.
- Mid-count (mtime=0x55), assert reset_n low asynchronously -> mtime_out, irq_out and CTRL clear immediately without a clock edge; after release, counting stays idle until EN is set.

Source files
------------

// File: rtl/timer_multi.sv
// timer_multi: memory-mapped machine timer with a 64-bit mtime counter,
// a programmable prescaler and CHANNELS 64-bit compare channels.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   address_in          byte address, word index taken from [6:2]
//   sel_in, read_in     peripheral select, read strobe (snapshot only)
//   write_mask_in       byte-lane write enables, all zero = no write
//   write_value_in      write data
//   read_value_out      combinational read data, 0 when not selected
//   irq_out             registered per-channel level interrupts
//   mtime_out           registered mtime, also feeds the time CSR
module timer_multi #(
   parameter int CHANNELS       = 2,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [31:0]         address_in,
   input  logic                sel_in,
   input  logic                read_in,
   output logic [31:0]         read_value_out,
   input  logic [3:0]          write_mask_in,
   input  logic [31:0]         write_value_in,
   output logic [CHANNELS-1:0] irq_out,
   output logic [63:0]         mtime_out
);

   localparam logic [4:0] IDX_MTIMEL   = 5'd0;
   localparam logic [4:0] IDX_MTIMEH   = 5'd1;
   localparam logic [4:0] IDX_CTRL     = 5'd2;
   localparam logic [4:0] IDX_PRESCALE = 5'd3;

   logic [4:0]                     idx;
   logic                           wr;
   logic                           tick;
   logic [63:0]                    mtime;
   logic [63:0]                    mtime_nx;
   logic [31:0]                    shadow_hi;
   logic [PRESCALE_WIDTH-1:0]      presc_cnt;
   logic [PRESCALE_WIDTH-1:0]      presc_nx;
   logic [PRESCALE_WIDTH-1:0]      div;
   logic [PRESCALE_WIDTH-1:0]      div_nx;
   logic                           en;
   logic                           en_nx;
   logic [CHANNELS-1:0]            ie;
   logic [CHANNELS-1:0]            ie_nx;
   logic [CHANNELS-1:0]            irq;
   logic [CHANNELS-1:0][63:0]      cmp;
   logic [CHANNELS-1:0][63:0]      cmp_nx;
   logic [31:0]                    reg_word;
   logic                           unused_addr;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] data,
      input logic [3:0]  mask
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
      end
      return r;
   endfunction

   // Word index of the low (hi=0) or high (hi=1) half of channel ch.
   function automatic logic [4:0] cmp_idx(input int ch, input int hi);
      return 5'(4 + 2*ch + hi);
   endfunction

   assign idx         = address_in[6:2];
   assign wr          = sel_in & (|write_mask_in);
   assign tick        = en & (presc_cnt == div);
   assign unused_addr = ^{address_in[31:7], address_in[1:0]};

   // A bus write to either mtime half overrides the tick: the other
   // half keeps its pre-cycle value, so no carry leaks across.
   always_comb begin
      mtime_nx = tick ? mtime + 64'd1 : mtime;
      if (wr && idx == IDX_MTIMEL) begin
         mtime_nx = {mtime[63:32],
                     merge(mtime[31:0], write_value_in, write_mask_in)};
      end else if (wr && idx == IDX_MTIMEH) begin
         mtime_nx = {merge(mtime[63:32], write_value_in, write_mask_in),
                     mtime[31:0]};
      end
   end

   always_comb begin
      if (!en) begin
         presc_nx = '0;
      end else if (tick) begin
         presc_nx = '0;
      end else begin
         presc_nx = presc_cnt + PRESCALE_WIDTH'(1);
      end
      div_nx = div;
      if (wr && idx == IDX_PRESCALE) begin
         presc_nx = '0;
         for (int k = 0; k < PRESCALE_WIDTH; k++) begin
            if (write_mask_in[k/8]) div_nx[k] = write_value_in[k];
         end
      end
   end

   always_comb begin
      en_nx = en;
      ie_nx = ie;
      if (wr && idx == IDX_CTRL) begin
         if (write_mask_in[0]) en_nx = write_value_in[0];
         if (write_mask_in[1]) ie_nx = write_value_in[8 +: CHANNELS];
      end
   end

   always_comb begin
      cmp_nx = cmp;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr && idx == cmp_idx(i, 0)) begin
            cmp_nx[i][31:0] = merge(cmp[i][31:0],
                                    write_value_in, write_mask_in);
         end
         if (wr && idx == cmp_idx(i, 1)) begin
            cmp_nx[i][63:32] = merge(cmp[i][63:32],
                                     write_value_in, write_mask_in);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mtime     <= '0;
         presc_cnt <= '0;
         div       <= '0;
         en        <= 1'b0;
         ie        <= '0;
         shadow_hi <= '0;
         cmp       <= '1;
         irq       <= '0;
      end else begin
         mtime     <= mtime_nx;
         presc_cnt <= presc_nx;
         div       <= div_nx;
         en        <= en_nx;
         ie        <= ie_nx;
         cmp       <= cmp_nx;
         // Compare uses this cycle's registered values, so a same-cycle
         // CMP or mtime write is only seen one cycle later.
         for (int i = 0; i < CHANNELS; i++) begin
            irq[i] <= ie[i] & (mtime >= cmp[i]);
         end
         // Latch the upper half alongside the MTIMEL read so a later
         // MTIMEH read pairs with it.
         if (sel_in && read_in && idx == IDX_MTIMEL) begin
            shadow_hi <= mtime[63:32];
         end
      end
   end

   always_comb begin
      reg_word = '0;
      case (idx)
         IDX_MTIMEL:   reg_word = mtime[31:0];
         IDX_MTIMEH:   reg_word = shadow_hi;
         IDX_CTRL: begin
            reg_word[0]             = en;
            reg_word[8 +: CHANNELS] = ie;
         end
         IDX_PRESCALE: reg_word[PRESCALE_WIDTH-1:0] = div;
         default: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (idx == cmp_idx(i, 0)) reg_word = cmp[i][31:0];
               if (idx == cmp_idx(i, 1)) reg_word = cmp[i][63:32];
            end
         end
      endcase
   end

   assign read_value_out = sel_in ? reg_word : 32'd0;
   assign irq_out        = irq;
   assign mtime_out      = mtime;

endmodule
